// File: rtl/forward_source_pipe.sv
// Forwarding-source pipeline for the 5-stage CPU: EX/MEM and MEM/WB result registers,
// EX and MEM forwarding views, register-file write port and load-use stall detection.
module forward_source_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic              id_rn_used,
    input  logic              id_rm_used,
    input  logic              cnt_clear,
    output logic [4:0]        exe_reg,
    output logic [DATA_W-1:0] exe_value,
    output logic [4:0]        mem_reg,
    output logic [DATA_W-1:0] mem_value,
    output logic              wb_en,
    output logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] wb_value,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    // X31 is the "no forward" register: downstream ignores matches on it.
    localparam logic [4:0]       XZR     = 5'd31;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              m_valid_r;
    logic              m_load_r;
    logic [4:0]        m_rd_r;
    logic [DATA_W-1:0] m_result_r;
    logic              w_valid_r;
    logic [4:0]        w_rd_r;
    logic [DATA_W-1:0] w_value_r;
    logic [CNT_W-1:0]  stall_count_r;
    logic              stall_s;
    logic [DATA_W-1:0] mem_value_s;

    function automatic logic src_hit(input logic used, input logic [4:0] src,
                                     input logic [4:0] rd);
        return used && (src == rd);
    endfunction

    // EX view: a load's EX result is only an address, so it is never forwarded.
    always_comb begin
        exe_reg   = XZR;
        exe_value = ex_result;
        if (ex_valid && ex_reg_write && !ex_mem_read) begin
            exe_reg = ex_rd;
        end else begin
            exe_reg = XZR;
        end
    end

    // Load-use hazard: decode reads the destination of a load still in EX.
    always_comb begin
        stall_s = 1'b0;
        if (ex_valid && ex_reg_write && ex_mem_read && (ex_rd != XZR)) begin
            stall_s = src_hit(id_rn_used, id_rn, ex_rd) | src_hit(id_rm_used, id_rm, ex_rd);
        end else begin
            stall_s = 1'b0;
        end
    end

    // M-stage result register, loaded every cycle from EX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_r  <= 1'b0;
            m_load_r   <= 1'b0;
            m_rd_r     <= XZR;
            m_result_r <= {DATA_W{1'b0}};
        end else begin
            m_valid_r  <= ex_valid && ex_reg_write && (ex_rd != XZR);
            m_load_r   <= ex_mem_read;
            m_rd_r     <= ex_rd;
            m_result_r <= ex_result;
        end
    end

    // MEM view: load data arrives from data memory in the same cycle.
    always_comb begin
        mem_value_s = m_result_r;
        if (m_load_r) begin
            mem_value_s = mem_load_data;
        end else begin
            mem_value_s = m_result_r;
        end
    end

    // W-stage register, loaded every cycle from M.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_valid_r <= 1'b0;
            w_rd_r    <= XZR;
            w_value_r <= {DATA_W{1'b0}};
        end else begin
            w_valid_r <= m_valid_r;
            w_rd_r    <= m_rd_r;
            w_value_r <= mem_value_s;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (cnt_clear) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign mem_reg     = m_valid_r ? m_rd_r : XZR;
    assign mem_value   = mem_value_s;
    assign wb_en       = w_valid_r;
    assign wb_reg      = w_valid_r ? w_rd_r : XZR;
    assign wb_value    = w_value_r;
    assign stall       = stall_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_forward_source_pipe.sv
// Directed bench for forward_source_pipe: vector table plus hand-written reset,
// counter-clear and counter-saturation sequences.
module tb_forward_source_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]  ex_rd, id_rn, id_rm;
    logic [63:0] ex_result, mem_load_data;
    logic        id_rn_used, id_rm_used, cnt_clear;

    logic [4:0]  exe_reg, mem_reg, wb_reg;
    logic [63:0] exe_value, mem_value, wb_value;
    logic        wb_en, stall;
    logic [31:0] stall_count;

    logic [4:0]  s_exe_reg, s_mem_reg, s_wb_reg;
    logic [63:0] s_exe_value, s_mem_value, s_wb_value;
    logic        s_wb_en, s_stall;
    logic [3:0]  s_stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forward_source_pipe #(.DATA_W(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_load_data(mem_load_data), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .cnt_clear(cnt_clear),
        .exe_reg(exe_reg), .exe_value(exe_value), .mem_reg(mem_reg), .mem_value(mem_value),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_value(wb_value), .stall(stall),
        .stall_count(stall_count)
    );

    forward_source_pipe #(.DATA_W(64), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_load_data(mem_load_data), .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .cnt_clear(cnt_clear),
        .exe_reg(s_exe_reg), .exe_value(s_exe_value), .mem_reg(s_mem_reg),
        .mem_value(s_mem_value), .wb_en(s_wb_en), .wb_reg(s_wb_reg), .wb_value(s_wb_value),
        .stall(s_stall), .stall_count(s_stall_count)
    );

    typedef struct {
        logic        v, rw, mr;
        logic [4:0]  rd;
        logic [63:0] res, mld;
        logic [4:0]  rn, rm;
        logic        rnu, rmu;
        logic [4:0]  e_reg;
        logic [63:0] e_val;
        logic        e_stall;
        logic [4:0]  m_reg;
        logic [63:0] m_val;
        logic        w_en;
        logic [4:0]  w_reg;
        logic [63:0] w_val;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                         input logic [63:0] res, input logic [63:0] mld,
                         input logic [4:0] rn, input logic [4:0] rm,
                         input logic rnu, input logic rmu, input logic clr);
        ex_valid = v; ex_reg_write = rw; ex_mem_read = mr; ex_rd = rd; ex_result = res;
        mem_load_data = mld; id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu;
        cnt_clear = clr;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bubble();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        //            v     rw    mr    rd     res        mld          rn     rm     rnu   rmu   e_reg  e_val      stl   m_reg  m_val        w_en  w_reg  w_val        cnt
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 5'd1,  64'h10,   64'h0,    5'd1,  5'd0,  1'b1, 1'b0, 5'd1,  64'h10,  1'b0, 5'd31, 64'h0,    1'b0, 5'd31, 64'h0,    32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'd3,  64'h5,    64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd3,  64'h5,   1'b0, 5'd1,  64'h10,   1'b0, 5'd31, 64'h0,    32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 5'd2,  64'h100,  64'h0,    5'd0,  5'd2,  1'b0, 1'b1, 5'd31, 64'h100, 1'b1, 5'd3,  64'h5,    1'b1, 5'd1,  64'h10,   32'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'hDEAD, 5'd0,  5'd2,  1'b0, 1'b1, 5'd31, 64'h0,   1'b0, 5'd2,  64'hDEAD, 1'b1, 5'd3,  64'h5,    32'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd31, 64'h0,   1'b0, 5'd31, 64'h0,    1'b1, 5'd2,  64'hDEAD, 32'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'd2,  64'h200,  64'h0,    5'd2,  5'd5,  1'b0, 1'b1, 5'd31, 64'h200, 1'b0, 5'd31, 64'h0,    1'b0, 5'd31, 64'h0,    32'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 5'd31, 64'h300,  64'h77,   5'd31, 5'd0,  1'b1, 1'b0, 5'd31, 64'h300, 1'b0, 5'd2,  64'h77,   1'b0, 5'd31, 64'h0,    32'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h99,   5'd0,  5'd0,  1'b0, 1'b0, 5'd31, 64'h0,   1'b0, 5'd31, 64'h99,   1'b1, 5'd2,  64'h77,   32'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 5'd31, 64'h55,   64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd31, 64'h55,  1'b0, 5'd31, 64'h0,    1'b0, 5'd31, 64'h99,   32'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 5'd4,  64'h44,   64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  64'h44,  1'b0, 5'd31, 64'h55,   1'b0, 5'd31, 64'h0,    32'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 5'd4,  64'h48,   64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  64'h48,  1'b0, 5'd4,  64'h44,   1'b0, 5'd31, 64'h55,   32'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd31, 64'h0,   1'b0, 5'd4,  64'h48,   1'b1, 5'd4,  64'h44,   32'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 5'd6,  64'h60,   64'h0,    5'd6,  5'd6,  1'b1, 1'b1, 5'd31, 64'h60,  1'b1, 5'd31, 64'h0,    1'b1, 5'd4,  64'h48,   32'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'hAB,   5'd6,  5'd6,  1'b1, 1'b1, 5'd31, 64'h0,   1'b0, 5'd6,  64'hAB,   1'b0, 5'd31, 64'h0,    32'd2};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  64'h0,    64'h0,    5'd0,  5'd0,  1'b0, 1'b0, 5'd31, 64'h0,   1'b0, 5'd31, 64'h0,    1'b1, 5'd6,  64'hAB,   32'd2};

        reset = 1'b0;
        bubble();
        #12;
        chk("reset_mem_reg", mem_reg, 64'd31);
        chk("reset_wb_en", wb_en, 64'd0);
        chk("reset_count", stall_count, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].rd, tbl[i].res, tbl[i].mld,
                  tbl[i].rn, tbl[i].rm, tbl[i].rnu, tbl[i].rmu, 1'b0);
            #2;
            chk($sformatf("row%0d_exe_reg", i), exe_reg, tbl[i].e_reg);
            chk($sformatf("row%0d_exe_value", i), exe_value, tbl[i].e_val);
            chk($sformatf("row%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("row%0d_mem_reg", i), mem_reg, tbl[i].m_reg);
            chk($sformatf("row%0d_mem_value", i), mem_value, tbl[i].m_val);
            chk($sformatf("row%0d_wb_en", i), wb_en, tbl[i].w_en);
            chk($sformatf("row%0d_wb_reg", i), wb_reg, tbl[i].w_reg);
            chk($sformatf("row%0d_wb_value", i), wb_value, tbl[i].w_val);
            chk($sformatf("row%0d_count", i), stall_count, tbl[i].cnt);
            @(posedge clk); #1;
        end

        // Mid-stream asynchronous reset with M and W both holding writers.
        drive(1'b1, 1'b1, 1'b0, 5'd7, 64'h70, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 5'd8, 64'h80, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_mem_reg", mem_reg, 64'd8);
        chk("pre_rst_wb_reg", wb_reg, 64'd7);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h5, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_mem_reg", mem_reg, 64'd31);
        chk("rst_mem_value", mem_value, 64'h0);
        chk("rst_wb_en", wb_en, 64'd0);
        chk("rst_wb_reg", wb_reg, 64'd31);
        chk("rst_wb_value", wb_value, 64'h0);
        chk("rst_count", stall_count, 64'd0);
        chk("rst_exe_reg_comb", exe_reg, 64'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bubble();
        #1;
        chk("rel_mem_reg", mem_reg, 64'd3);
        chk("rel_mem_value", mem_value, 64'h5);
        chk("rel_no_stale_wb", wb_en, 64'd0);
        @(posedge clk); #1;
        chk("rel_wb_en", wb_en, 64'd1);
        chk("rel_wb_reg", wb_reg, 64'd3);
        chk("rel_wb_value", wb_value, 64'h5);

        // Three separate load-use stalls, then cnt_clear together with a fourth.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 5'd2, 64'h100, 64'h0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b0);
            #1;
            chk($sformatf("cnt_stall%0d", k), stall, 64'd1);
            @(posedge clk); #1;
            bubble();
            @(posedge clk); #1;
        end
        drive(1'b1, 1'b1, 1'b1, 5'd2, 64'h100, 64'h0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("cnt_before_clear", stall_count, 64'd3);
        chk("cnt_clear_stall", stall, 64'd1);
        @(posedge clk); #1;
        bubble();
        #1;
        chk("cnt_after_clear", stall_count, 64'd0);

        // Saturation: a held load-use condition stalls every cycle.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd9, 64'h0, 64'h0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_small_count", s_stall_count, 64'd15);
        chk("sat_wide_count", stall_count, 64'd20);
        bubble();
        @(posedge clk); #1;
        chk("sat_small_hold", s_stall_count, 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
